kernel_distributor_pipe: RTL and testbench

- Registered, parametrised successor to the combinational KernelBufferDistributor.
- Takes D kernel-buffer lanes of W bits plus a routing control word. Emits the permuted lanes through a 2-stage valid/ready pipeline.
- Adds broadcast, masked-rotate and identity modes, plus a handshake beat counter.
- Sits between the kernel buffer banks and the PE-array kernel inputs.

---
 rtl/kernel_distributor_pipe_pkg.sv | 14 +
 rtl/kernel_distributor_pipe_if.sv | 31 +++
 rtl/kernel_distributor_pipe_lane_router.sv | 41 ++++
 rtl/kernel_distributor_pipe.sv | 104 ++++++++++
 tb/tb_kernel_distributor_pipe.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/kernel_distributor_pipe_pkg.sv
// Shared definitions for the kernel distributor pipeline: routing modes and
// the layout of the per-beat control word.
package kernel_dist_pkg;

    localparam logic [1:0] MODE_ROT   = 2'd0;
    localparam logic [1:0] MODE_BCAST = 2'd1;
    localparam logic [1:0] MODE_MROT  = 2'd2;
    localparam logic [1:0] MODE_IDENT = 2'd3;

    // Control word is {trc, bank}; each field is depth bits wide, bank at the bottom.
    localparam int unsigned CTRL_FIELD_CNT = 2;
    localparam int unsigned CTRL_BANK_LSB  = 0;

endpackage

// File: rtl/kernel_distributor_pipe_if.sv
// Source/consumer handshake bundle of the kernel distributor pipeline.
interface kernel_distributor_pipe_if
    import kernel_dist_pkg::*;
#(
    parameter int unsigned depth = 3,
    parameter int unsigned W     = 8,
    parameter int unsigned CW    = 16
);
    localparam int unsigned D = 1 << depth;

    logic [W*D-1:0]                  ip;
    logic [CTRL_FIELD_CNT*depth-1:0] controlSignal;
    logic [1:0]                      mode;
    logic                            in_valid;
    logic                            in_ready;
    logic [W*D-1:0]                  op;
    logic                            out_valid;
    logic                            out_ready;
    logic [CW-1:0]                   beat_count;

    modport master (
        output ip, controlSignal, mode, in_valid, out_ready,
        input  in_ready, op, out_valid, beat_count
    );

    modport slave (
        input  ip, controlSignal, mode, in_valid, out_ready,
        output in_ready, op, out_valid, beat_count
    );

endinterface

// File: rtl/kernel_distributor_pipe_lane_router.sv
// Combinational per-mode lane permutation between the stage-1 registers and op.
module kernel_lane_router
    import kernel_dist_pkg::*;
#(
    parameter int unsigned depth = 3,
    parameter int unsigned W     = 8
) (
    input  logic [W*(1<<depth)-1:0] ip_i,
    input  logic [depth-1:0]        trc_i,
    input  logic [depth-1:0]        bank_i,
    input  logic [1:0]              mode_i,
    output logic [W*(1<<depth)-1:0] op_o
);
    localparam int unsigned D = 1 << depth;

    logic [W-1:0] lane_in [D];

    always_comb begin
        for (int unsigned j = 0; j < D; j++) begin
            lane_in[j] = ip_i[W*j +: W];
        end
    end

    // Source index wraps by natural depth-bit overflow.
    always_comb begin
        op_o = '0;
        for (int unsigned k = 0; k < D; k++) begin
            logic [depth-1:0] kk;
            logic [depth-1:0] src;
            kk  = depth'(k);
            src = kk + trc_i;
            case (mode_i)
                MODE_ROT:   op_o[W*k +: W] = lane_in[src];
                MODE_BCAST: op_o[W*k +: W] = lane_in[bank_i];
                MODE_MROT:  op_o[W*k +: W] = (kk <= bank_i) ? lane_in[src] : '0;
                default:    op_o[W*k +: W] = lane_in[kk];
            endcase
        end
    end

endmodule

// File: rtl/kernel_distributor_pipe.sv
// Two-stage valid/ready pipeline routing D kernel-buffer lanes to the PE array,
// with a wrapping count of completed output handshakes.
module kernel_distributor_pipe
    import kernel_dist_pkg::*;
#(
    parameter int unsigned depth = 3,
    parameter int unsigned W     = 8,
    parameter int unsigned CW    = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    kernel_distributor_pipe_if.slave io
);
    localparam int unsigned D       = 1 << depth;
    localparam int unsigned DW      = W * D;
    localparam int unsigned TRC_LSB = CTRL_BANK_LSB + depth;

    logic             s1_valid_q, s1_valid_d;
    logic [DW-1:0]    s1_ip_q,    s1_ip_d;
    logic [depth-1:0] s1_trc_q,   s1_trc_d;
    logic [depth-1:0] s1_bank_q,  s1_bank_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [DW-1:0]    op_q,       op_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [DW-1:0]    route_c;
    logic             s2_adv_c, s1_load_c, s2_load_c;

    // in_ready depends combinationally on out_ready so a full pipe can accept while draining.
    assign s2_adv_c  = !s2_valid_q || io.out_ready;
    assign s1_load_c = io.in_valid && io.in_ready;
    assign s2_load_c = s1_valid_q && s2_adv_c;

    assign io.in_ready   = !s1_valid_q || s2_adv_c;
    assign io.out_valid  = s2_valid_q;
    assign io.op         = op_q;
    assign io.beat_count = cnt_q;

    kernel_lane_router #(
        .depth (depth),
        .W     (W)
    ) u_router (
        .ip_i   (s1_ip_q),
        .trc_i  (s1_trc_q),
        .bank_i (s1_bank_q),
        .mode_i (s1_mode_q),
        .op_o   (route_c)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ip_d    = s1_ip_q;
        s1_trc_d   = s1_trc_q;
        s1_bank_d  = s1_bank_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        op_d       = op_q;
        cnt_d      = cnt_q;

        if (s1_load_c) begin
            s1_valid_d = 1'b1;
            s1_ip_d    = io.ip;
            s1_trc_d   = io.controlSignal[TRC_LSB +: depth];
            s1_bank_d  = io.controlSignal[CTRL_BANK_LSB +: depth];
            s1_mode_d  = io.mode;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load_c) begin
            op_d = route_c;
        end

        if (s2_valid_q && io.out_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ip_q    <= '0;
            s1_trc_q   <= '0;
            s1_bank_q  <= '0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            op_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ip_q    <= s1_ip_d;
            s1_trc_q   <= s1_trc_d;
            s1_bank_q  <= s1_bank_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_kernel_distributor_pipe.sv
// Directed bench for kernel_distributor_pipe: routing modes, latency, backpressure,
// async reset and beat counter wrap.
module tb_kernel_distributor_pipe;
    import kernel_dist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kernel_distributor_pipe_if #(.depth(3), .W(8), .CW(16)) bus ();
    kernel_distributor_pipe_if #(.depth(3), .W(8), .CW(4))  bus4 ();

    kernel_distributor_pipe #(.depth(3), .W(8), .CW(16)) dut (
        .CLK   (clk),
        .reset (rst),
        .io    (bus)
    );

    kernel_distributor_pipe #(.depth(3), .W(8), .CW(4)) dut4 (
        .CLK   (clk),
        .reset (rst),
        .io    (bus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lanes listed lane0 first.
    function automatic logic [63:0] pk(input int l0, l1, l2, l3, l4, l5, l6, l7);
        return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input int t, input int b, input logic [1:0] m);
        bus.ip            = d;
        bus.controlSignal = {3'(t), 3'(b)};
        bus.mode          = m;
        bus.in_valid      = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    logic [63:0] id_lanes;
    logic [63:0] b0, b1, b2, b3;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        id_lanes = pk(0, 1, 2, 3, 4, 5, 6, 7);
        b0 = {8{8'hA0}};
        b1 = {8{8'hA1}};
        b2 = {8{8'hA2}};
        b3 = {8{8'hA3}};

        bus.ip = '0; bus.controlSignal = '0; bus.mode = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus4.ip = id_lanes; bus4.controlSignal = '0; bus4.mode = MODE_IDENT;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;

        #2;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_op", bus.op, 64'd0);
        check_val("rst_beat_count", 64'(bus.beat_count), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Rotate by 3, 2-cycle latency
        drive(id_lanes, 3, 0, MODE_ROT);
        tick();
        check_val("rot_lat1_valid", 64'(bus.out_valid), 64'd0);
        idle();
        tick();
        check_val("rot_lat2_valid", 64'(bus.out_valid), 64'd1);
        check_val("rot3_op", bus.op, pk(3, 4, 5, 6, 7, 0, 1, 2));
        check_val("rot_cnt_before", 64'(bus.beat_count), 64'd0);
        tick();
        check_val("rot_drained", 64'(bus.out_valid), 64'd0);
        check_val("rot_cnt_after", 64'(bus.beat_count), 64'd1);

        // Broadcast then identity, back-to-back
        drive(id_lanes, 0, 5, MODE_BCAST);
        tick();
        drive(id_lanes, 7, 0, MODE_IDENT);
        tick();
        check_val("bcast_valid", 64'(bus.out_valid), 64'd1);
        check_val("bcast_op", bus.op, pk(5, 5, 5, 5, 5, 5, 5, 5));
        idle();
        tick();
        check_val("ident_valid", 64'(bus.out_valid), 64'd1);
        check_val("ident_op", bus.op, pk(0, 1, 2, 3, 4, 5, 6, 7));
        tick();
        check_val("b2b_drained", 64'(bus.out_valid), 64'd0);
        check_val("b2b_cnt", 64'(bus.beat_count), 64'd3);

        // Masked rotate, partial and full mask
        drive(id_lanes, 1, 2, MODE_MROT);
        tick();
        drive(id_lanes, 1, 7, MODE_MROT);
        tick();
        check_val("mrot_b2_op", bus.op, pk(1, 2, 3, 0, 0, 0, 0, 0));
        idle();
        tick();
        check_val("mrot_b7_op", bus.op, pk(1, 2, 3, 4, 5, 6, 7, 0));
        tick();
        check_val("mrot_cnt", 64'(bus.beat_count), 64'd5);

        // Backpressure: four beats, pipe fills after two
        bus.out_ready = 1'b0;
        drive(b0, 0, 0, MODE_IDENT);
        tick();
        check_val("bp_ready_1", 64'(bus.in_ready), 64'd1);
        drive(b1, 0, 0, MODE_IDENT);
        tick();
        check_val("bp_ready_2", 64'(bus.in_ready), 64'd0);
        check_val("bp_valid", 64'(bus.out_valid), 64'd1);
        check_val("bp_op_b0", bus.op, b0);
        drive(b2, 0, 0, MODE_IDENT);
        tick();
        check_val("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        check_val("bp_hold_op1", bus.op, b0);
        tick();
        check_val("bp_hold_op2", bus.op, b0);
        check_val("bp_hold_cnt", 64'(bus.beat_count), 64'd5);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check_val("bp_op_b1", bus.op, b1);
        drive(b3, 0, 0, MODE_IDENT);
        tick();
        check_val("bp_op_b2", bus.op, b2);
        idle();
        tick();
        check_val("bp_op_b3", bus.op, b3);
        tick();
        check_val("bp_drained", 64'(bus.out_valid), 64'd0);
        check_val("bp_cnt", 64'(bus.beat_count), 64'd9);

        // Async reset with both stages full
        bus.out_ready = 1'b0;
        drive(b1, 0, 0, MODE_IDENT);
        tick();
        drive(b2, 0, 0, MODE_IDENT);
        tick();
        idle();
        check_val("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        check_val("rst_pre_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("arst_op", bus.op, 64'd0);
        check_val("arst_cnt", 64'(bus.beat_count), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(id_lanes, 2, 0, MODE_ROT);
        tick();
        check_val("post_rst_lat1", 64'(bus.out_valid), 64'd0);
        idle();
        tick();
        check_val("post_rst_lat2", 64'(bus.out_valid), 64'd1);
        check_val("post_rst_op", bus.op, pk(2, 3, 4, 5, 6, 7, 0, 1));
        tick();
        check_val("post_rst_cnt", 64'(bus.beat_count), 64'd1);

        // 4-bit counter wrap: 17 handshakes
        bus4.in_valid = 1'b1;
        repeat (17) tick();
        bus4.in_valid = 1'b0;
        check_val("wrap_cnt15", 64'(bus4.beat_count), 64'd15);
        tick();
        check_val("wrap_cnt0", 64'(bus4.beat_count), 64'd0);
        tick();
        check_val("wrap_cnt1", 64'(bus4.beat_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
